// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
// Holds the arbiter FSM state encoding, the default sizing of the arbiter
// (requester count, packet length limit, inter-byte gap timeout) and a small
// helper that sizes requester-index vectors.
package uart_pkg;

  localparam int unsigned NUM_REQ_DEF = 32'd4;
  localparam int unsigned MAX_PKT_DEF = 32'd16;
  localparam int unsigned GAP_TO_DEF  = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  // Width of a requester index; never below one bit so a single-requester
  // build still has a legal vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   req  [NUM_REQ-1:0] in  - request vector
//   ptr  [IDX_W-1:0]   in  - index of the requester with highest priority
//   sel  [NUM_REQ-1:0] out - one-hot first request at or after ptr (wraps)
//   any                out - at least one request is present
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] sel,
  output logic               any
);

  logic             taken;
  logic [IDX_W-1:0] idx;

  // Walk the requesters starting at ptr; the first hit wins, later hits are masked.
  always_comb begin
    sel   = '0;
    taken = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx      = IDX_W'((32'(ptr) + off) % NUM_REQ);
      sel[idx] = sel[idx] | (req[idx] & ~taken);
      taken    = taken | req[idx];
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds byte streams from several
// requesters into a single UART transmitter (uart_tx). tx_start/tx_data drive
// the transmitter's i_start_trigger/i_tx_data and tx_busy is its o_tx_busy;
// the baud tick is generated outside this block.
// A grant is held for a whole packet (until req_last, or MAX_PKT bytes), and
// is revoked if the owner leaves req_valid low for GAP_TO cycles while the
// transmitter is free.
// Ports:
//   clk                       in  - rising-edge clock
//   reset                     in  - asynchronous, active-high reset
//   req_valid [NUM_REQ-1:0]   in  - requester i has a byte available
//   req_data  [8*NUM_REQ-1:0] in  - byte of requester i on [8i+7:8i]
//   req_last  [NUM_REQ-1:0]   in  - current byte ends requester i's packet
//   req_ready [NUM_REQ-1:0]   out - one-cycle accept pulse (one-hot or zero)
//   grant     [NUM_REQ-1:0]   out - one-hot owner of the transmitter
//   tx_start                  out - one-cycle start pulse to the transmitter
//   tx_data   [7:0]           out - byte to transmit, held until next start
//   tx_busy                   in  - transmitter busy
//   gap_abort                 out - one-cycle pulse when a grant times out
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned MAX_PKT = MAX_PKT_DEF,
  parameter int unsigned GAP_TO  = GAP_TO_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 gap_abort
);

  localparam int unsigned IDX_W  = idx_width(NUM_REQ);
  localparam int unsigned BCNT_W = $clog2(MAX_PKT + 32'd1);
  localparam int unsigned GCNT_W = $clog2(GAP_TO + 32'd1);

  arb_state_t          state, state_next;
  logic [NUM_REQ-1:0]  grant_next, ready_next;
  logic                start_next, abort_next;
  logic [7:0]          data_next;
  logic [IDX_W-1:0]    rr_ptr, ptr_next;
  logic [BCNT_W-1:0]   byte_cnt, bcnt_next;
  logic [GCNT_W-1:0]   gap_cnt, gcnt_next;
  logic                last_byte, last_next;

  logic [NUM_REQ-1:0]  pick_sel;
  logic                pick_any;
  logic                g_valid, g_last;
  logic [7:0]          g_data;
  logic [IDX_W-1:0]    g_idx, g_after;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .sel (pick_sel),
    .any (pick_any)
  );

  // Fold the granted requester's lines down to scalars; grant is one-hot so OR-ing is exact.
  always_comb begin
    g_valid = |(req_valid & grant);
    g_last  = |(req_last & grant);
    g_data  = 8'h00;
    g_idx   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      g_data = g_data | (req_data[i*8 +: 8] & {8{grant[i]}});
      g_idx  = g_idx | (grant[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
    g_after = (g_idx == IDX_W'(NUM_REQ - 32'd1)) ? {IDX_W{1'b0}} : (g_idx + 1'b1);
  end

  // Next-state and next-output logic of the arbiter FSM.
  always_comb begin
    state_next = state;
    grant_next = grant;
    ready_next = '0;
    start_next = 1'b0;
    data_next  = tx_data;
    abort_next = 1'b0;
    ptr_next   = rr_ptr;
    bcnt_next  = byte_cnt;
    gcnt_next  = gap_cnt;
    last_next  = last_byte;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          grant_next = pick_sel;
          gcnt_next  = '0;
          state_next = ST_SEND;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (g_valid) begin
          // The busy guard only matters if the transmitter misbehaves; a
          // start is never issued on top of a frame in progress.
          if (!tx_busy) begin
            start_next = 1'b1;
            data_next  = g_data;
            ready_next = grant;
            last_next  = g_last;
            bcnt_next  = byte_cnt + 1'b1;
            gcnt_next  = '0;
            state_next = ST_WAIT_ACK;
          end else begin
            state_next = ST_SEND;
          end
        end else if (gap_cnt == GCNT_W'(GAP_TO - 32'd1)) begin
          grant_next = '0;
          abort_next = 1'b1;
          ptr_next   = g_after;
          bcnt_next  = '0;
          gcnt_next  = '0;
          state_next = ST_IDLE;
        end else begin
          gcnt_next  = gap_cnt + 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_next = ST_WAIT_DONE;
        end else begin
          state_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_byte || (byte_cnt == BCNT_W'(MAX_PKT))) begin
            grant_next = '0;
            ptr_next   = g_after;
            bcnt_next  = '0;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_SEND;
          end
        end else begin
          state_next = ST_WAIT_DONE;
        end
      end
      default: begin
        grant_next = '0;
        bcnt_next  = '0;
        gcnt_next  = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register plus every registered output and counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant     <= '0;
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      gap_abort <= 1'b0;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      last_byte <= 1'b0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      req_ready <= ready_next;
      tx_start  <= start_next;
      tx_data   <= data_next;
      gap_abort <= abort_next;
      rr_ptr    <= ptr_next;
      byte_cnt  <= bcnt_next;
      gap_cnt   <= gcnt_next;
      last_byte <= last_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a UART busy model and a
// packet-level arbitration model that predicts the order of transmitted bytes.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR    = 4;
  localparam int MP    = 16;
  localparam int GT    = 1024;
  localparam int FRAME = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*NR-1:0] req_data;
  logic            tx_start, tx_busy, gap_abort;
  logic [7:0]      tx_data;

  typedef struct {
    int         owner;
    logic [7:0] data;
  } tx_t;

  tx_t        exp_q[$];
  logic [8:0] rq [NR][$];
  int         start_cyc[$];
  int         pass_cnt = 0, total = 0, cyc = 0;
  int         fall_cyc = 0, abort_cyc = 0, rel_cyc = 0, n_abort = 0, n_start = 0;
  logic [7:0] last_sent = 8'h00;
  logic [NR-1:0] prev_grant = '0;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_PKT(MP), .GAP_TO(GT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .gap_abort(gap_abort)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  task automatic push_exp(input int owner, input logic [7:0] data);
    tx_t t;
    t.owner = owner;
    t.data  = data;
    exp_q.push_back(t);
  endtask

  // Packet-level round robin: from ptr, the first non-empty requester owns the
  // transmitter until its last byte or MP bytes, then priority moves past it.
  task automatic predict(input int start_ptr);
    logic [8:0] cq [NR][$];
    logic [8:0] e;
    int ptr, owner, n;
    bit more;
    for (int i = 0; i < NR; i++) cq[i] = rq[i];
    ptr  = start_ptr;
    more = 1'b1;
    while (more) begin
      owner = -1;
      for (int k = 0; k < NR; k++)
        if (owner < 0 && cq[(ptr + k) % NR].size() > 0) owner = (ptr + k) % NR;
      if (owner < 0) more = 1'b0;
      else begin
        n = 0;
        e = 9'h000;
        while (!e[8] && n < MP && cq[owner].size() > 0) begin
          e = cq[owner].pop_front();
          push_exp(owner, e[7:0]);
          n++;
        end
        ptr = (owner + 1) % NR;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NR; i++) rq[i].delete();
    exp_q.delete();
    start_cyc.delete();
    n_abort = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    int left;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && grant == '0 && !tx_busy) ok = 1'b1;
    end
    chk("drain_timeout", ok, 1);
    left = 0;
    for (int i = 0; i < NR; i++) left += rq[i].size();
    chk("bytes_left", left, 0);
  endtask

  // Requesters: present the queue head, pop it on the accept pulse.
  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      for (int i = 0; i < NR; i++) begin
        if (rq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[i*8 +: 8] = rq[i][0][7:0];
          req_last[i]        = rq[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[i*8 +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // UART model: busy rises the cycle after tx_start and lasts FRAME cycles.
  initial begin
    bit pend;
    int bcnt;
    tx_busy = 1'b0; pend = 1'b0; bcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        tx_busy = 1'b0; pend = 1'b0; bcnt = 0;
      end else begin
        if (pend) begin
          tx_busy = 1'b1; bcnt = FRAME; pend = 1'b0;
        end else if (tx_busy) begin
          bcnt--;
          if (bcnt == 0) begin
            tx_busy  = 1'b0;
            fall_cyc = cyc;
          end
        end
        if (tx_start) pend = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model and the output rules.
  initial begin
    tx_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_sent = 8'h00;
      end else begin
        chk("grant_onehot0", $onehot0(grant), 1);
        chk("ready_outside_grant", req_ready & ~grant, 0);
        chk("ready_onehot0", $onehot0(req_ready), 1);
        chk("start_while_busy", tx_start & tx_busy, 0);
        if (tx_start) begin
          n_start++;
          start_cyc.push_back(cyc);
          chk("start_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tx_data", tx_data, e.data);
            chk("start_grant", grant, 32'd1 << e.owner);
            chk("start_ready", req_ready, 32'd1 << e.owner);
            last_sent = e.data;
          end
        end else begin
          chk("tx_data_hold", tx_data, last_sent);
          chk("ready_without_start", req_ready, 0);
        end
        if (gap_abort) begin
          n_abort++;
          abort_cyc = cyc;
          chk("abort_grant", grant, 0);
        end
        if (prev_grant != '0 && grant == '0) rel_cyc = cyc;
      end
      prev_grant = grant;
    end
  end

  initial begin
    bit ok;
    int ns;
    logic [31:0] packed_owners;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_abort", gap_abort, 0);
    reset = 1'b0;

    // Single requester, three bytes.
    @(negedge clk);
    start_cyc.delete();
    rq[0].push_back(9'h041); rq[0].push_back(9'h042); rq[0].push_back(9'h143);
    predict(0);
    chk("s1_model_len", exp_q.size(), 3);
    chk("s1_model_bytes", {8'h00, exp_q[0].data, exp_q[1].data, exp_q[2].data}, 32'h00414243);
    wait_drain(400);
    chk("s1_starts", start_cyc.size(), 3);
    if (start_cyc.size() == 3) begin
      chk("s1_period_a", start_cyc[1] - start_cyc[0], FRAME + 3);
      chk("s1_period_b", start_cyc[2] - start_cyc[1], FRAME + 3);
    end
    chk("s1_release_after_fall", rel_cyc - fall_cyc, 1);

    // Contention between requesters 0 and 2, single-byte packets.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      rq[0].push_back(9'h1A0 | 9'(k));
      rq[2].push_back(9'h1C0 | 9'(k));
    end
    predict(0);
    packed_owners = '0;
    foreach (exp_q[k]) packed_owners = (packed_owners << 4) | 32'(exp_q[k].owner);
    chk("s2_model_order", packed_owners, 32'h00020202);
    wait_drain(600);

    // Requester 1 holds a 4-byte packet while requester 3 waits.
    do_reset();
    rq[1].push_back(9'h0B0); rq[1].push_back(9'h0B1); rq[1].push_back(9'h0B2); rq[1].push_back(9'h1B3);
    rq[3].push_back(9'h1D0);
    predict(0);
    packed_owners = '0;
    foreach (exp_q[k]) packed_owners = (packed_owners << 4) | 32'(exp_q[k].owner);
    chk("s3_model_order", packed_owners, 32'h00011113);
    wait_drain(600);

    // Long stream from 0 is cut at MP bytes in favour of waiting requester 1.
    do_reset();
    for (int k = 0; k < 20; k++) rq[0].push_back((k == 19) ? (9'h100 | 9'(k)) : 9'(k));
    rq[1].push_back(9'h1B1);
    predict(0);
    chk("s5_model_len", exp_q.size(), 21);
    chk("s5_model_cut_owner", exp_q[16].owner, 1);
    chk("s5_model_last_of_burst", exp_q[15].data, 8'h0F);
    wait_drain(2000);

    // Gap timeout: requester 0 stalls after its first byte, requester 1 waits.
    do_reset();
    rq[0].push_back(9'h010);
    rq[1].push_back(9'h120);
    push_exp(0, 8'h10);
    push_exp(1, 8'h20);
    ok = 1'b0;
    for (int k = 0; k < GT + 200 && !ok; k++) begin
      @(negedge clk);
      if (n_abort > 0) ok = 1'b1;
    end
    chk("gap_seen", ok, 1);
    chk("gap_latency", abort_cyc - fall_cyc, GT + 1);
    wait_drain(300);
    chk("gap_abort_count", n_abort, 1);

    // Reset while waiting for the frame to finish, then restart from requester 0.
    do_reset();
    rq[2].push_back(9'h170);
    predict(0);
    wait_drain(200);
    rq[1].push_back(9'h081); rq[1].push_back(9'h082); rq[1].push_back(9'h183);
    predict(3);
    chk("s4_model_owner", exp_q[0].owner, 1);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (tx_busy) ok = 1'b1;
    end
    chk("s4_busy_seen", ok, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("s4_rst_grant", grant, 0);
    chk("s4_rst_ready", req_ready, 0);
    chk("s4_rst_start", tx_start, 0);
    chk("s4_rst_data", tx_data, 8'h00);
    chk("s4_rst_abort", gap_abort, 0);
    for (int i = 0; i < NR; i++) rq[i].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ns = n_start;
    repeat (20) @(negedge clk);
    chk("s4_no_start_after_reset", n_start - ns, 0);
    chk("s4_idle_grant", grant, 0);
    rq[3].push_back(9'h193);
    rq[0].push_back(9'h190);
    predict(0);
    chk("s4_model_restart_owner", exp_q[0].owner, 0);
    wait_drain(300);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
